// File: rtl/glitch_pkg.sv
// Shared types and reset-time constants for the glitch sequencer.
package glitch_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ARMED,
    DELAY,
    PULSE,
    GAP
  } state_t;

  localparam int CNT_W_DEF = 32;
  localparam int REP_W_DEF = 8;
  localparam int ATT_W_DEF = 16;

  // Config held after reset: immediate, single one-cycle pulse.
  localparam int CFG_RST_DELAY = 0;
  localparam int CFG_RST_WIDTH = 1;
  localparam int CFG_RST_GAP   = 1;
  localparam int CFG_RST_COUNT = 1;

endpackage

// File: rtl/trigger_sync.sv
// Two-flop synchroniser for the asynchronous target trigger, plus rising-edge detect.
module trigger_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic trigger_in,
  output logic trig_rise
);

  logic s1;
  logic s2;
  logic s3;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= trigger_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign trig_rise = s2 & ~s3;

endmodule

// File: rtl/glitch_sequencer.sv
// Arms on request, waits for a synchronised trigger edge, then emits a timed
// train of glitch pulses using one shared down-counter and a repeat counter.
module glitch_sequencer
  import glitch_pkg::*;
#(
  parameter int   CNT_W      = CNT_W_DEF,
  parameter int   REP_W      = REP_W_DEF,
  parameter int   ATT_W      = ATT_W_DEF,
  parameter logic GLITCH_POL = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [CNT_W-1:0] cfg_delay,
  input  logic [CNT_W-1:0] cfg_width,
  input  logic [CNT_W-1:0] cfg_gap,
  input  logic [REP_W-1:0] cfg_count,
  input  logic             arm,
  input  logic             abort,
  input  logic             trigger_in,
  output logic             glitch_out,
  output logic             armed,
  output logic             busy,
  output logic             done,
  output logic [ATT_W-1:0] attempts
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [REP_W-1:0] REP_ONE = REP_W'(1);
  localparam logic [ATT_W-1:0] ATT_ONE = ATT_W'(1);

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic [REP_W-1:0] rep;
  logic [REP_W-1:0] rep_next;
  logic             train_end;
  logic             trig_rise;

  logic [CNT_W-1:0] delay_q;
  logic [CNT_W-1:0] width_q;
  logic [CNT_W-1:0] gap_q;
  logic [REP_W-1:0] count_q;
  logic [ATT_W-1:0] att_q;
  logic             glitch_q;
  logic             done_q;

  trigger_sync u_trigger_sync (
    .clk        (clk),
    .rst_n      (rst_n),
    .trigger_in (trigger_in),
    .trig_rise  (trig_rise)
  );

  assign cfg_ready = (state == IDLE);

  // Zero width/gap/count would make a degenerate train, so they are stored as 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      delay_q <= CNT_W'(CFG_RST_DELAY);
      width_q <= CNT_W'(CFG_RST_WIDTH);
      gap_q   <= CNT_W'(CFG_RST_GAP);
      count_q <= REP_W'(CFG_RST_COUNT);
    end else if (cfg_valid && cfg_ready) begin
      delay_q <= cfg_delay;
      width_q <= (cfg_width == '0) ? CNT_ONE : cfg_width;
      gap_q   <= (cfg_gap == '0) ? CNT_ONE : cfg_gap;
      count_q <= (cfg_count == '0) ? REP_ONE : cfg_count;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    rep_next   = rep;
    train_end  = 1'b0;
    if (abort) begin
      state_next = IDLE;
      cnt_next   = '0;
      rep_next   = '0;
    end else begin
      case (state)
        IDLE: begin
          if (arm) state_next = ARMED;
        end
        ARMED: begin
          if (trig_rise) begin
            rep_next = count_q - REP_ONE;
            if (delay_q == '0) begin
              state_next = PULSE;
              cnt_next   = width_q - CNT_ONE;
            end else begin
              state_next = DELAY;
              cnt_next   = delay_q - CNT_ONE;
            end
          end
        end
        DELAY: begin
          if (cnt == '0) begin
            state_next = PULSE;
            cnt_next   = width_q - CNT_ONE;
          end else begin
            cnt_next = cnt - CNT_ONE;
          end
        end
        PULSE: begin
          if (cnt == '0) begin
            if (rep == '0) begin
              state_next = IDLE;
              train_end  = 1'b1;
            end else begin
              state_next = GAP;
              cnt_next   = gap_q - CNT_ONE;
              rep_next   = rep - REP_ONE;
            end
          end else begin
            cnt_next = cnt - CNT_ONE;
          end
        end
        GAP: begin
          if (cnt == '0) begin
            state_next = PULSE;
            cnt_next   = width_q - CNT_ONE;
          end else begin
            cnt_next = cnt - CNT_ONE;
          end
        end
        default: begin
          state_next = IDLE;
          cnt_next   = '0;
          rep_next   = '0;
        end
      endcase
    end
  end

  // glitch_out is registered from the next state so it lines up with PULSE exactly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      rep      <= '0;
      glitch_q <= ~GLITCH_POL;
      done_q   <= 1'b0;
      att_q    <= '0;
    end else begin
      state    <= state_next;
      cnt      <= cnt_next;
      rep      <= rep_next;
      glitch_q <= (state_next == PULSE) ? GLITCH_POL : ~GLITCH_POL;
      done_q   <= train_end;
      if (train_end && (att_q != '1)) att_q <= att_q + ATT_ONE;
    end
  end

  assign glitch_out = glitch_q;
  assign armed      = (state == ARMED);
  assign busy       = (state == DELAY) || (state == PULSE) || (state == GAP);
  assign done       = done_q;
  assign attempts   = att_q;

endmodule

// File: tb/tb_glitch_sequencer.sv
// Directed bench for glitch_sequencer: train timing, config clamping, trigger/arm
// qualification, abort, asynchronous reset and attempt saturation.
module tb_glitch_sequencer;

  logic        clk;
  logic        rst_n;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [31:0] cfg_delay;
  logic [31:0] cfg_width;
  logic [31:0] cfg_gap;
  logic [7:0]  cfg_count;
  logic        arm;
  logic        abort;
  logic        trigger_in;
  logic        glitch_out;
  logic        armed;
  logic        busy;
  logic        done;
  logic [15:0] attempts;

  logic        cfg_ready2;
  logic        glitch_out2;
  logic        armed2;
  logic        busy2;
  logic        done2;
  logic [1:0]  attempts2;

  int errors = 0;
  int checks = 0;

  logic [127:0] g_hist;
  logic [127:0] d_hist;

  glitch_sequencer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_delay  (cfg_delay),
    .cfg_width  (cfg_width),
    .cfg_gap    (cfg_gap),
    .cfg_count  (cfg_count),
    .arm        (arm),
    .abort      (abort),
    .trigger_in (trigger_in),
    .glitch_out (glitch_out),
    .armed      (armed),
    .busy       (busy),
    .done       (done),
    .attempts   (attempts)
  );

  // Narrow attempt counter sharing all stimulus, used to see saturation.
  glitch_sequencer #(.ATT_W(2)) dut_sat (
    .clk        (clk),
    .rst_n      (rst_n),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready2),
    .cfg_delay  (cfg_delay),
    .cfg_width  (cfg_width),
    .cfg_gap    (cfg_gap),
    .cfg_count  (cfg_count),
    .arm        (arm),
    .abort      (abort),
    .trigger_in (trigger_in),
    .glitch_out (glitch_out2),
    .armed      (armed2),
    .busy       (busy2),
    .done       (done2),
    .attempts   (attempts2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  // Negedge k after the trigger is raised follows posedge E0+k-1, so a pulse
  // starting at edge E0+2+delay is first seen at negedge 3+delay.
  function automatic logic [127:0] exp_glitch(int d, int w, int g, int c);
    logic [127:0] v;
    v = '0;
    for (int p = 0; p < c; p++)
      for (int i = 0; i < w; i++) v[3 + d + p * (w + g) + i] = 1'b1;
    return v;
  endfunction

  function automatic logic [127:0] exp_done(int d, int w, int g, int c);
    logic [127:0] v;
    v = '0;
    v[3 + d + c * w + (c - 1) * g] = 1'b1;
    return v;
  endfunction

  task automatic load_cfg(input logic [31:0] d, input logic [31:0] w, input logic [31:0] g,
                          input logic [7:0] c, input logic with_arm);
    cfg_valid = 1'b1;
    cfg_delay = d;
    cfg_width = w;
    cfg_gap   = g;
    cfg_count = c;
    arm       = with_arm;
    @(negedge clk);
    cfg_valid = 1'b0;
    arm       = 1'b0;
  endtask

  task automatic arm_only();
    arm = 1'b1;
    @(negedge clk);
    arm = 1'b0;
  endtask

  // Raise the trigger, record glitch_out/done for nc negedges, optionally
  // re-pulse the trigger at retrig and pulse abort at abort_at.
  task automatic applyStimulus(input int nc, input int retrig, input int abort_at,
                               output logic [127:0] g, output logic [127:0] d);
    g = '0;
    d = '0;
    trigger_in = 1'b1;
    for (int k = 1; k <= nc; k++) begin
      @(negedge clk);
      g[k] = glitch_out;
      d[k] = done;
      trigger_in = (k < 2) || (retrig > 0 && k >= retrig && k < retrig + 3);
      abort = (k == abort_at);
    end
    trigger_in = 1'b0;
    abort = 1'b0;
  endtask

  initial begin
    rst_n      = 1'b0;
    cfg_valid  = 1'b0;
    cfg_delay  = '0;
    cfg_width  = '0;
    cfg_gap    = '0;
    cfg_count  = '0;
    arm        = 1'b0;
    abort      = 1'b0;
    trigger_in = 1'b0;

    repeat (2) @(negedge clk);
    checkOutput("rst_glitch", glitch_out, 0);
    checkOutput("rst_cfg_ready", cfg_ready, 1);
    checkOutput("rst_armed", armed, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_attempts", attempts, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single long pulse, config and arm in the same cycle.
    load_cfg(10, 36, 1, 1, 1'b1);
    checkOutput("t1_armed", armed, 1);
    checkOutput("t1_cfg_ready", cfg_ready, 0);
    applyStimulus(60, 0, 0, g_hist, d_hist);
    checkOutput("t1_glitch", g_hist, exp_glitch(10, 36, 1, 1));
    checkOutput("t1_first_hi", {g_hist[13], g_hist[12]}, 2'b10);
    checkOutput("t1_last_hi", {g_hist[49], g_hist[48]}, 2'b01);
    checkOutput("t1_done", d_hist, exp_done(10, 36, 1, 1));
    checkOutput("t1_attempts", attempts, 1);
    checkOutput("t1_idle", {armed, busy, cfg_ready}, 3'b001);

    // Three one-cycle pulses, three idle cycles apart.
    load_cfg(0, 1, 3, 3, 1'b1);
    applyStimulus(20, 0, 0, g_hist, d_hist);
    checkOutput("t2_glitch", g_hist, 128'h0888);
    checkOutput("t2_done", d_hist, 128'h1000);
    checkOutput("t2_attempts", attempts, 2);
    checkOutput("t2_sat_attempts", attempts2, 2);

    // Zero width/gap/count clamp to 1.
    load_cfg(2, 0, 0, 0, 1'b0);
    arm_only();
    applyStimulus(12, 0, 0, g_hist, d_hist);
    checkOutput("t3_glitch", g_hist, exp_glitch(2, 1, 1, 1));
    checkOutput("t3_done", d_hist, exp_done(2, 1, 1, 1));

    // Config offered while ARMED is refused and the old config stays.
    arm_only();
    cfg_valid = 1'b1;
    cfg_delay = 7;
    cfg_width = 7;
    cfg_gap   = 7;
    cfg_count = 7;
    #1;
    checkOutput("t3_cfg_ready_armed", cfg_ready, 0);
    @(negedge clk);
    cfg_valid = 1'b0;
    applyStimulus(12, 0, 0, g_hist, d_hist);
    checkOutput("t3_cfg_kept", g_hist, exp_glitch(2, 1, 1, 1));
    checkOutput("t3_attempts", attempts, 4);
    checkOutput("t3_sat_attempts", attempts2, 3);

    // Trigger while IDLE does nothing.
    load_cfg(0, 4, 1, 1, 1'b0);
    applyStimulus(15, 0, 0, g_hist, d_hist);
    checkOutput("t4_idle_trig", {g_hist, d_hist[0]}, 0);
    checkOutput("t4_idle_state", {armed, busy}, 2'b00);

    // Second trigger edge during the train is ignored.
    load_cfg(5, 8, 2, 2, 1'b1);
    applyStimulus(35, 6, 0, g_hist, d_hist);
    checkOutput("t4_retrig_glitch", g_hist, exp_glitch(5, 8, 2, 2));
    checkOutput("t4_retrig_done", d_hist, exp_done(5, 8, 2, 2));
    checkOutput("t4_attempts", attempts, 5);

    // Abort in the middle of a long pulse.
    load_cfg(0, 100, 1, 1, 1'b1);
    applyStimulus(30, 0, 10, g_hist, d_hist);
    checkOutput("t5_abort_glitch", g_hist, 128'h07F8);
    checkOutput("t5_abort_done", d_hist, 0);
    checkOutput("t5_abort_attempts", attempts, 5);
    checkOutput("t5_abort_state", {armed, busy, cfg_ready}, 3'b001);
    load_cfg(0, 4, 1, 1, 1'b1);
    applyStimulus(12, 0, 0, g_hist, d_hist);
    checkOutput("t5_rearm_glitch", g_hist, exp_glitch(0, 4, 1, 1));
    checkOutput("t5_rearm_attempts", attempts, 6);

    // Reset during the gap of a two-pulse train.
    load_cfg(0, 2, 10, 2, 1'b1);
    trigger_in = 1'b1;
    repeat (2) @(negedge clk);
    trigger_in = 1'b0;
    repeat (4) @(negedge clk);
    checkOutput("t6_gap_busy", {busy, glitch_out}, 2'b10);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("t6_rst_outputs", {glitch_out, cfg_ready, armed, busy, done}, 5'b01000);
    checkOutput("t6_rst_attempts", attempts, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset during a pulse drops glitch_out without a clock edge.
    load_cfg(0, 50, 1, 1, 1'b1);
    trigger_in = 1'b1;
    repeat (2) @(negedge clk);
    trigger_in = 1'b0;
    repeat (4) @(negedge clk);
    checkOutput("t6_pulse_high", glitch_out, 1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("t6_pulse_rst_low", glitch_out, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset config is delay 0, width 1, count 1.
    arm_only();
    applyStimulus(8, 0, 0, g_hist, d_hist);
    checkOutput("t6_default_cfg", g_hist, 128'h08);
    checkOutput("t6_default_done", d_hist, 128'h10);

    for (int n = 0; n < 4; n++) begin
      arm_only();
      applyStimulus(8, 0, 0, g_hist, d_hist);
    end
    checkOutput("sat_wide_attempts", attempts, 5);
    checkOutput("sat_narrow_attempts", attempts2, 3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
